// File: rtl/btn_debounce.sv
// Debounces N active-low button pins into a clean pressed level plus
// single-cycle press, release and long-press pulses on a shared tick timebase.
module btn_debounce #(
  parameter int N          = 8,
  parameter int TICK_DIV   = 8000,
  parameter int DB_TICKS   = 10,
  parameter int LONG_TICKS = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_btn_n,
  output logic [N-1:0] o_btn_state,
  output logic [N-1:0] o_btn_press,
  output logic [N-1:0] o_btn_release,
  output logic [N-1:0] o_btn_long,
  output logic         o_any_event,
  output logic         o_tick
);

  localparam int          PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]  DB_LAST   = 4'(DB_TICKS - 1);
  localparam logic [9:0]  LONG_MAX  = 10'(LONG_TICKS);
  localparam logic [9:0]  LONG_LAST = 10'(LONG_TICKS - 1);

  typedef enum logic {
    S_RELEASED = 1'b0,
    S_PRESSED  = 1'b1
  } btn_st_t;

  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic [N-1:0]  r_press;
  logic [N-1:0]  r_release;
  logic [N-1:0]  r_long;
  logic          r_any;
  logic [N-1:0]  w_press_next;
  logic [N-1:0]  w_release_next;
  logic [N-1:0]  w_long_next;
  logic [N-1:0]  w_state;

  // Sync flops idle at 1 (released) so a held button re-debounces after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_any     <= 1'b0;
    end else begin
      r_sync1   <= i_btn_n;
      r_sync2   <= r_sync1;
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
        r_tick  <= 1'b0;
      end
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_long    <= w_long_next;
      r_any     <= |(w_press_next | w_release_next | w_long_next);
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_btn
      btn_st_t    r_st;
      btn_st_t    w_st_next;
      logic [3:0] r_db_cnt;
      logic [3:0] w_db_next;
      logic [9:0] r_long_cnt;
      logic [9:0] w_long_cnt_next;
      logic       w_p;
      logic       w_press;
      logic       w_release;
      logic       w_long;

      assign w_p = ~r_sync2[gi];

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_st       <= S_RELEASED;
          r_db_cnt   <= '0;
          r_long_cnt <= '0;
        end else begin
          r_st       <= w_st_next;
          r_db_cnt   <= w_db_next;
          r_long_cnt <= w_long_cnt_next;
        end
      end

      always_comb begin
        w_st_next       = r_st;
        w_db_next       = r_db_cnt;
        w_long_cnt_next = r_long_cnt;
        w_press         = 1'b0;
        w_release       = 1'b0;
        w_long          = 1'b0;

        if (w_p != (r_st == S_PRESSED)) begin
          if (r_tick) begin
            if (r_db_cnt == DB_LAST) begin
              w_db_next = '0;
              if (r_st == S_RELEASED) begin
                w_st_next = S_PRESSED;
                w_press   = 1'b1;
              end else begin
                w_st_next = S_RELEASED;
                w_release = 1'b1;
              end
            end else begin
              w_db_next = r_db_cnt + 4'd1;
            end
          end
        end else begin
          w_db_next = '0;
        end

        // An accepted release wins over a long pulse landing on the same tick.
        if (r_st == S_RELEASED || w_release) begin
          w_long_cnt_next = '0;
        end else if (r_tick && r_long_cnt < LONG_MAX) begin
          w_long_cnt_next = r_long_cnt + 10'd1;
          w_long          = (r_long_cnt == LONG_LAST);
        end
      end

      assign w_state[gi]        = (r_st == S_PRESSED);
      assign w_press_next[gi]   = w_press;
      assign w_release_next[gi] = w_release;
      assign w_long_next[gi]    = w_long;
    end
  endgenerate

  assign o_btn_state   = w_state;
  assign o_btn_press   = r_press;
  assign o_btn_release = r_release;
  assign o_btn_long    = r_long;
  assign o_any_event   = r_any;
  assign o_tick        = r_tick;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: expected pulses with their exact cycle
// are queued when the pins are driven and matched as the DUT emits them.
module tb_btn_debounce;

  localparam int N  = 8;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int LT = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_n;
  logic [N-1:0] btn_state, btn_press, btn_release, btn_long;
  logic         any_event, tick;

  btn_debounce #(.N(N), .TICK_DIV(TD), .DB_TICKS(DB), .LONG_TICKS(LT)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_btn_n       (btn_n),
    .o_btn_state   (btn_state),
    .o_btn_press   (btn_press),
    .o_btn_release (btn_release),
    .o_btn_long    (btn_long),
    .o_any_event   (any_event),
    .o_tick        (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] vec;
    int          cyc;
  } evt_t;

  evt_t exp_q[$];
  int   k = 0;
  int   n_total = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  // Cycle (edges since last reset edge) at which a change driven after edge e0 is accepted.
  function automatic int acc_cyc(input int e0);
    int c;
    c = e0 + 3;
    if (c < TD + 1) c = TD + 1;
    while (c % TD != 1) c++;
    return c + (DB - 1) * TD;
  endfunction

  task automatic push_evt(input logic [N-1:0] p, input logic [N-1:0] r,
                          input logic [N-1:0] l, input int cyc);
    evt_t e;
    e.vec = {|(p | r | l), p, r, l};
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check_val("drain", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  // Monitor: every pulse cycle must match the queue head in value and cycle.
  initial begin
    logic [24:0] obs;
    evt_t        e;
    forever begin
      @(posedge clk);
      if (reset == 1'b0) k = 0;
      else k++;
      #1;
      obs = {any_event, btn_press, btn_release, btn_long};
      if (|obs) begin
        if (exp_q.size() == 0) begin
          check_val("spurious", {7'd0, obs}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("evt", {7'd0, obs}, {7'd0, e.vec});
          check_val("evt_cyc", k, e.cyc);
        end
        $display("cyc %0d any=%0b press=%02h release=%02h long=%02h",
                 k, any_event, btn_press, btn_release, btn_long);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, c1, p;

    // 1: reset with all pins low, then tick cadence
    reset = 1'b0;
    btn_n = 8'h00;
    repeat (10) @(negedge clk);
    check_val("rst_state", {24'd0, btn_state}, 32'd0);
    check_val("rst_out", {7'd0, tick, any_event, btn_press, btn_release, btn_long}, 32'd0);
    btn_n = 8'hFF;
    reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #2;
      check_val($sformatf("tick%0d", c), {31'd0, tick}, {31'd0, (c % TD == 0)});
    end

    // 2: clean press/release on button 0
    @(negedge clk);
    btn_n[0] = 1'b0;
    push_evt(8'h01, 8'h00, 8'h00, acc_cyc(k));
    wait_drain(200);
    check_val("state_b0", {24'd0, btn_state}, 32'h01);
    btn_n[0] = 1'b1;
    push_evt(8'h00, 8'h01, 8'h00, acc_cyc(k));
    wait_drain(200);
    check_val("state_b0_rel", {24'd0, btn_state}, 32'h00);

    // 3: bounce on button 2 then settle pressed
    for (int i = 0; i < 12; i++) begin
      btn_n[2] = ~btn_n[2];
      repeat (5) @(negedge clk);
    end
    btn_n[2] = 1'b0;
    push_evt(8'h04, 8'h00, 8'h00, acc_cyc(k));
    wait_drain(200);
    check_val("state_b2", {24'd0, btn_state}, 32'h04);
    btn_n[2] = 1'b1;
    push_evt(8'h00, 8'h04, 8'h00, acc_cyc(k));
    wait_drain(200);

    // 4: long press on button 4
    btn_n[4] = 1'b0;
    p = acc_cyc(k);
    push_evt(8'h10, 8'h00, 8'h00, p);
    push_evt(8'h00, 8'h00, 8'h10, p + LT * TD);
    repeat (40 * TD) @(negedge clk);
    check_val("state_b4", {24'd0, btn_state}, 32'h10);
    check_val("long_pending", exp_q.size(), 0);
    btn_n[4] = 1'b1;
    push_evt(8'h00, 8'h10, 8'h00, acc_cyc(k));
    wait_drain(200);
    check_val("state_b4_rel", {24'd0, btn_state}, 32'h00);

    // 5: all buttons at once
    btn_n = 8'h00;
    push_evt(8'hFF, 8'h00, 8'h00, acc_cyc(k));
    wait_drain(200);
    check_val("state_all", {24'd0, btn_state}, 32'hFF);
    btn_n = 8'hFF;
    push_evt(8'h00, 8'hFF, 8'h00, acc_cyc(k));
    wait_drain(200);

    // 6: reset after two ticks of mismatch discards the press
    btn_n[1] = 1'b0;
    e0 = k;
    c1 = acc_cyc(e0) - (DB - 1) * TD;
    for (int i = 0; i < 100 && k < c1 + TD; i++) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("midrst_state", {24'd0, btn_state}, 32'd0);
    check_val("midrst_out", {8'd0, any_event, btn_press, btn_release, btn_long}, 32'd0);
    reset = 1'b1;
    push_evt(8'h02, 8'h00, 8'h00, acc_cyc(k));
    wait_drain(200);
    check_val("state_b1", {24'd0, btn_state}, 32'h02);
    btn_n[1] = 1'b1;
    push_evt(8'h00, 8'h02, 8'h00, acc_cyc(k));
    wait_drain(200);

    repeat (20) @(negedge clk);
    check_val("final_q", exp_q.size(), 0);
    check_val("final_state", {24'd0, btn_state}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
